connect_four_ai_seq: RTL
========================

Name: connect_four_ai_seq

Overview:
Parametrised, sequential successor to the combinational Connect Four move selector. It scores one candidate column per clock in centre-out order, keeping a running best. Compared with the previous block, it adds configurable board geometry and connect length, a mode input (defensive/offensive weighting), an explicit win > block > heuristic priority, and a start/done handshake. It sits between the game-state register and the move-commit logic.

Parameters:
ROWS, 6, board rows; row 0 is the bottom row.
COLS, 7, board columns.
CONNECT, 4, pieces in a line needed to win (2..min(ROWS,COLS)).
SCORE_W, 6, score width; SCORE_MAX = 2^SCORE_W-1.
W_HI, 5, weight of a run of 2 or more for the emphasised side.
W_LO, 3, weight of a run of 2 or more for the other side.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  request evaluation; honoured only in IDLE
board  in  2*ROWS*COLS  cell (r,c) at bits [(r*COLS+c)*2 +: 2]; bit0 = AI piece, bit1 = opponent piece, 00 = empty
mode  in  1  0 = defensive (opponent runs weighted W_HI), 1 = offensive (AI runs weighted W_HI)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; results valid from this cycle and held until the next start
ai_move  out  $clog2(COLS)  chosen column
best_score  out  SCORE_W  score of the chosen column
valid_move  out  1  0 if every column is full

Behaviour:
- Reset (async, reset=0): state IDLE; busy=0, done=0, ai_move=0, best_score=0, valid_move=0. An assertion mid-scan aborts the scan with no done pulse.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE, start=1: latch board and mode, clear the running best (found=0), set idx=0, go to SCAN.
- start is ignored in SCAN and DONE. The latched board is immune to later changes on the board input.
- SCAN: evaluate column order[idx] each cycle. order = COLS/2, COLS/2-1, COLS/2+1, COLS/2-2, ... (COLS=7: 3,2,4,1,5,0,6). After idx=COLS-1, go to DONE.
- Candidate update: a column is eligible if its height < ROWS. It replaces the best if found=0 or its score is strictly greater than the best, so ties keep the earlier column in centre-out order.
- DONE: done=1 for one cycle and busy falls. ai_move/best_score = best; valid_move = found. If found=0, ai_move=COLS/2 and best_score=0.
- Latency: start sampled at edge 0 -> done high after edge COLS+1 (COLS=7: 8 cycles). busy is high for COLS cycles.
- Column score (target cell r = height(c), where height = number of non-empty cells in column c):
  - For the 7 directions (down, left, right, down-left, down-right, up-left, up-right), count contiguous AI and opponent runs from the neighbour outward. Each count is capped at CONNECT-1 and stops at the board edge.
  - Lines: down; left+right; down-left+up-right; down-right+up-left.
  - Any AI line >= CONNECT-1 gives SCORE_MAX (win).
  - Otherwise, any opponent line >= CONNECT-1 gives SCORE_MAX-1 (block).
  - Otherwise, sum over all 14 runs: run 1 scores 1; run >= 2 scores W_HI for the emphasised side, W_LO for the other. The sum saturates at SCORE_MAX-2.
- Cells with both bits set are treated as empty.

Decomposition:
- Package connect_four_pkg holds: cell encoding constants (EMPTY, AI, OPP), a direction enum, the score-class constants (WIN = SCORE_MAX, BLOCK = SCORE_MAX-1, HEUR_CAP = SCORE_MAX-2), and a function mapping idx to the centre-out column.
- Sub-module connect_four_col_scorer is purely combinational. Inputs are the latched board, column, and mode; outputs are eligible and score. It is parametrised identically.
- The top level holds the FSM, idx counter, board/mode latch, and best registers.

Test Plan:
- Empty board, start, mode=0 -> done at cycle 8; ai_move=3, best_score=0, valid_move=1; busy high for cycles 1-7.
- AI at (0,0),(0,1),(0,2); opponent at (0,5),(1,5),(2,5) -> ai_move=3, best_score=63 (win beats the block in column 5).
- Opponent at (0,2),(1,2),(2,2); AI at (0,0),(0,4),(0,6) -> ai_move=2, best_score=62.
- Column 3 full with alternating pieces, rest empty -> ai_move=2 (symmetric tie with column 4, resolved centre-out), valid_move=1. A fully filled board -> valid_move=0, ai_move=3, best_score=0.
- start re-pulsed and board changed during SCAN -> no restart; result matches the original board. reset=0 at cycle 4 -> outputs zero, no done; a new start later completes normally.
- ROWS=7, COLS=9, CONNECT=5: AI run of 4 at row 0, cols 0-3 -> ai_move=4, best_score=63, done at cycle 10.

Source files
------------

// File: rtl/connect_four_pkg.sv
// Shared definitions for the sequential Connect Four move selector.
//   - cell encodings (bit0 = AI piece, bit1 = opponent piece)
//   - scan FSM state and line-direction enums
//   - score-class helpers (win / block / heuristic cap) for any score width
//   - helper functions: direction deltas and the centre-out column order
package connect_four_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_AI    = 2'b01;
    localparam logic [1:0] CELL_OPP   = 2'b10;

    typedef enum logic [2:0] {
        DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_DL, DIR_DR, DIR_UL, DIR_UR
    } dir_e;
    localparam int NUM_DIRS = 7;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

    function automatic int score_win(input int score_w);
        return (1 << score_w) - 1;
    endfunction

    function automatic int score_block(input int score_w);
        return (1 << score_w) - 2;
    endfunction

    function automatic int score_heur_cap(input int score_w);
        return (1 << score_w) - 3;
    endfunction

    // Row delta; row 0 is the bottom, so "down" is -1.
    function automatic int dir_dr(input dir_e d);
        case (d)
            DIR_DOWN, DIR_DL, DIR_DR: return -1;
            DIR_UL, DIR_UR:           return 1;
            default:                  return 0;
        endcase
    endfunction

    function automatic int dir_dc(input dir_e d);
        case (d)
            DIR_LEFT, DIR_DL, DIR_UL:  return -1;
            DIR_RIGHT, DIR_DR, DIR_UR: return 1;
            default:                   return 0;
        endcase
    endfunction

    // idx 0,1,2,3,... -> centre, centre-1, centre+1, centre-2, ...
    function automatic int center_out_col(input int idx, input int cols);
        return (idx % 2 == 0) ? cols / 2 + idx / 2 : cols / 2 - (idx + 1) / 2;
    endfunction

endpackage

// File: rtl/connect_four_ai_seq_if.sv
// Request/result bundle of the move selector.
//   master: drives start, board, mode; receives busy, done, ai_move,
//           best_score, valid_move.
//   slave : the selector itself.
interface connect_four_ai_seq_if #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int SCORE_W = 6
);
    logic                       start;
    logic [2*ROWS*COLS-1:0]     board;
    logic                       mode;
    logic                       busy;
    logic                       done;
    logic [$clog2(COLS)-1:0]    ai_move;
    logic [SCORE_W-1:0]         best_score;
    logic                       valid_move;

    modport master (
        output start, board, mode,
        input  busy, done, ai_move, best_score, valid_move
    );

    modport slave (
        input  start, board, mode,
        output busy, done, ai_move, best_score, valid_move
    );
endinterface

// File: rtl/connect_four_col_scorer.sv
// Combinational score of dropping an AI piece into one column.
//   board_i    : latched board, cell (r,c) at [(r*COLS+c)*2 +: 2]
//   col_i      : column under evaluation
//   mode_i     : 0 = opponent runs emphasised, 1 = AI runs emphasised
//   eligible_o : column still has room
//   score_o    : win > block > weighted-run heuristic
module connect_four_col_scorer
    import connect_four_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int CONNECT = 4,
    parameter int SCORE_W = 6,
    parameter int W_HI    = 5,
    parameter int W_LO    = 3
) (
    input  logic [2*ROWS*COLS-1:0]  board_i,
    input  logic [$clog2(COLS)-1:0] col_i,
    input  logic                    mode_i,
    output logic                    eligible_o,
    output logic [SCORE_W-1:0]      score_o
);

    // Both bits set is not a legal piece and reads as empty.
    function automatic logic [1:0] cell_at(input logic [2*ROWS*COLS-1:0] b,
                                           input int r, input int c);
        logic [1:0] v;
        v = b[(r*COLS+c)*2 +: 2];
        return (v == 2'b11) ? CELL_EMPTY : v;
    endfunction

    // Contiguous run of `side` from the neighbour outward, capped at CONNECT-1.
    function automatic int run_len(input logic [2*ROWS*COLS-1:0] b, input int r0,
                                   input int c0, input dir_e d, input logic [1:0] side);
        int   n;
        int   r;
        int   c;
        logic going;
        n = 0;
        r = r0;
        c = c0;
        going = 1'b1;
        for (int k = 1; k < CONNECT; k++) begin
            r = r + dir_dr(d);
            c = c + dir_dc(d);
            if (going && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                if (cell_at(b, r, c) == side) n++;
                else going = 1'b0;
            end else begin
                going = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic int run_pts(input int n, input logic emph);
        if (n == 0) return 0;
        if (n == 1) return 1;
        return emph ? W_HI : W_LO;
    endfunction

    int   height;
    int   sum;
    int   ai_run  [NUM_DIRS];
    int   opp_run [NUM_DIRS];
    logic ai_win;
    logic opp_win;

    always_comb begin
        height = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (cell_at(board_i, r, int'(col_i)) != CELL_EMPTY) height++;
        end
        eligible_o = (height < ROWS);

        sum = 0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            ai_run[d]  = run_len(board_i, height, int'(col_i), dir_e'(d), CELL_AI);
            opp_run[d] = run_len(board_i, height, int'(col_i), dir_e'(d), CELL_OPP);
            sum = sum + run_pts(ai_run[d], mode_i) + run_pts(opp_run[d], !mode_i);
        end

        ai_win  = (ai_run[DIR_DOWN] >= CONNECT-1)
               || (ai_run[DIR_LEFT] + ai_run[DIR_RIGHT] >= CONNECT-1)
               || (ai_run[DIR_DL] + ai_run[DIR_UR] >= CONNECT-1)
               || (ai_run[DIR_DR] + ai_run[DIR_UL] >= CONNECT-1);
        opp_win = (opp_run[DIR_DOWN] >= CONNECT-1)
               || (opp_run[DIR_LEFT] + opp_run[DIR_RIGHT] >= CONNECT-1)
               || (opp_run[DIR_DL] + opp_run[DIR_UR] >= CONNECT-1)
               || (opp_run[DIR_DR] + opp_run[DIR_UL] >= CONNECT-1);

        if (sum > score_heur_cap(SCORE_W)) sum = score_heur_cap(SCORE_W);

        if (ai_win)       score_o = SCORE_W'(score_win(SCORE_W));
        else if (opp_win) score_o = SCORE_W'(score_block(SCORE_W));
        else              score_o = SCORE_W'(sum);
    end

endmodule

// File: rtl/connect_four_ai_seq.sv
// Sequential Connect Four move selector: one candidate column per clock in
// centre-out order, keeping the running best.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : slave side of connect_four_ai_seq_if (start/board/mode in,
//                busy/done/ai_move/best_score/valid_move out)
module connect_four_ai_seq
    import connect_four_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int CONNECT = 4,
    parameter int SCORE_W = 6,
    parameter int W_HI    = 5,
    parameter int W_LO    = 3
) (
    input  logic               clk,
    input  logic               reset,
    connect_four_ai_seq_if.slave bus
);

    localparam int CW = $clog2(COLS);

    state_e                 state_q;
    logic [2*ROWS*COLS-1:0] board_q;
    logic                   mode_q;
    logic [CW-1:0]          idx_q;
    logic                   found_q;
    logic [CW-1:0]          best_col_q;
    logic [SCORE_W-1:0]     best_score_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CW-1:0]          ai_move_q;
    logic [SCORE_W-1:0]     score_q;
    logic                   valid_q;

    logic [CW-1:0]          scan_col_d;
    logic                   cand_eligible;
    logic [SCORE_W-1:0]     cand_score;
    logic                   take_d;

    assign scan_col_d = CW'(center_out_col(int'(idx_q), COLS));

    connect_four_col_scorer #(
        .ROWS(ROWS), .COLS(COLS), .CONNECT(CONNECT),
        .SCORE_W(SCORE_W), .W_HI(W_HI), .W_LO(W_LO)
    ) u_scorer (
        .board_i    (board_q),
        .col_i      (scan_col_d),
        .mode_i     (mode_q),
        .eligible_o (cand_eligible),
        .score_o    (cand_score)
    );

    // Strictly greater: ties keep the column seen earlier (closer to centre).
    assign take_d = cand_eligible && (!found_q || cand_score > best_score_q);

    // busy/done are registered from the state, so they trail it by one cycle:
    // busy covers the COLS scan cycles and done follows immediately after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            board_q      <= '0;
            mode_q       <= 1'b0;
            idx_q        <= '0;
            found_q      <= 1'b0;
            best_col_q   <= '0;
            best_score_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ai_move_q    <= '0;
            score_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            busy_q <= (state_q == ST_SCAN);
            done_q <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        board_q      <= bus.board;
                        mode_q       <= bus.mode;
                        found_q      <= 1'b0;
                        best_score_q <= '0;
                        idx_q        <= '0;
                        state_q      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (take_d) begin
                        found_q      <= 1'b1;
                        best_col_q   <= scan_col_d;
                        best_score_q <= cand_score;
                    end
                    if (idx_q == CW'(COLS-1)) state_q <= ST_DONE;
                    else                      idx_q   <= idx_q + CW'(1);
                end
                ST_DONE: begin
                    ai_move_q <= found_q ? best_col_q : CW'(COLS/2);
                    score_q   <= found_q ? best_score_q : '0;
                    valid_q   <= found_q;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ai_move    = ai_move_q;
    assign bus.best_score = score_q;
    assign bus.valid_move = valid_q;

endmodule
